param_datapath: RTL and testbench

PARAM_DATAPATH -- requirements
Module: param_datapath

---
 rtl/param_datapath_if.sv | 33 +++
 rtl/param_datapath.sv | 184 ++++++++++++++++++
 tb/tb_param_datapath.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_datapath_if.sv
// Control, data and status signals of param_datapath, grouped for port connection.
// The slave modport is the datapath; the master modport is the sequencer that drives it.
interface param_datapath_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  logic [4:0]               src_sel;
  logic                     ba_out;
  logic                     reg_wr;
  logic [$clog2(NREGS)-1:0] reg_idx;
  logic                     y_in, z_in, hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, out_in;
  logic [1:0]               mdr_sel;
  logic                     inc_pc;
  logic [3:0]               alu_op;
  logic                     alu_start;
  logic [WIDTH-1:0]         imm, mem_rdata, inport_data;
  logic [WIDTH-1:0]         bus, mem_addr, mem_wdata, outport_data, ir_out, pc_out;
  logic                     busy, done, dbz;

  modport master (
    output src_sel, ba_out, reg_wr, reg_idx, y_in, z_in, hi_in, lo_in, pc_in, ir_in,
           mar_in, mdr_in, out_in, mdr_sel, inc_pc, alu_op, alu_start, imm, mem_rdata,
           inport_data,
    input  bus, mem_addr, mem_wdata, outport_data, ir_out, pc_out, busy, done, dbz
  );

  modport slave (
    input  src_sel, ba_out, reg_wr, reg_idx, y_in, z_in, hi_in, lo_in, pc_in, ir_in,
           mar_in, mdr_in, out_in, mdr_sel, inc_pc, alu_op, alu_start, imm, mem_rdata,
           inport_data,
    output bus, mem_addr, mem_wdata, outport_data, ir_out, pc_out, busy, done, dbz
  );
endinterface

// File: rtl/param_datapath.sv
// Single-bus CPU datapath: register file, special registers, single-cycle ALU and
// a WIDTH+1 cycle signed MUL/DIV unit writing the ZHI:ZLO pair.
module param_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input logic             clk,
  input logic             reset,
  param_datapath_if.slave io
);
  localparam int IW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r [NREGS];
  logic [WIDTH-1:0] y, zhi, zlo, hi, lo, pc, ir, mar, mdr, outr, inport;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_div, busy, done, dbz;
  logic [WIDTH-1:0] bus, alu_res, mc_hi, mc_lo;
  logic             mc_dbz, mc_op;
  logic [SW-1:0]    sh;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   sa, sb;

  always_comb begin
    bus = '0;
    if (int'(io.src_sel) < NREGS) begin
      if (!(io.ba_out && io.src_sel == 5'd0)) bus = r[io.src_sel[IW-1:0]];
    end else begin
      case (io.src_sel)
        5'd16:   bus = hi;
        5'd17:   bus = lo;
        5'd18:   bus = zhi;
        5'd19:   bus = zlo;
        5'd20:   bus = pc;
        5'd21:   bus = mdr;
        5'd22:   bus = inport;
        5'd23:   bus = io.imm;
        default: bus = '0;
      endcase
    end
  end

  assign mc_op = (io.alu_op == 4'd11) || (io.alu_op == 4'd12);

  always_comb begin
    sh = bus[SW-1:0];
    case (io.alu_op)
      4'd0:    alu_res = y + bus;
      4'd1:    alu_res = y - bus;
      4'd2:    alu_res = y & bus;
      4'd3:    alu_res = y | bus;
      4'd4:    alu_res = y >> sh;
      4'd5:    alu_res = $signed(y) >>> sh;
      4'd6:    alu_res = y << sh;
      4'd7:    alu_res = (y >> sh) | (y << (WIDTH - int'(sh)));
      4'd8:    alu_res = (y << sh) | (y >> (WIDTH - int'(sh)));
      4'd9:    alu_res = '0 - bus;
      4'd10:   alu_res = ~bus;
      default: alu_res = bus;
    endcase
  end

  // Result is formed from the operands captured at start and committed on the DONE edge.
  always_comb begin
    sa     = op_a;
    sb     = op_b;
    prod   = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
    mc_hi  = prod[2*WIDTH-1:WIDTH];
    mc_lo  = prod[WIDTH-1:0];
    mc_dbz = 1'b0;
    if (op_div) begin
      if (op_b == '0) begin
        mc_lo  = '1;
        mc_hi  = op_a;
        mc_dbz = 1'b1;
      end else if (op_a == MOST_NEG && op_b == '1) begin
        mc_lo = MOST_NEG;
        mc_hi = '0;
      end else begin
        mc_lo = sa / sb;
        mc_hi = sa % sb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_div <= 1'b0;
      zhi    <= '0;
      zlo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.alu_start && mc_op) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            op_a   <= y;
            op_b   <= bus;
            op_div <= (io.alu_op == 4'd12);
            dbz    <= 1'b0;
          end else if (io.z_in && (io.inc_pc || !mc_op)) begin
            // z_in with MUL/DIV opcodes writes nothing unless inc_pc forces bus+1
            zhi <= '0;
            zlo <= io.inc_pc ? bus + WIDTH'(1) : alu_res;
          end
        end
        RUN: begin
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          zhi   <= mc_hi;
          zlo   <= mc_lo;
          dbz   <= mc_dbz;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r[i] <= '0;
      y      <= '0;
      hi     <= '0;
      lo     <= '0;
      pc     <= '0;
      ir     <= '0;
      mar    <= '0;
      mdr    <= '0;
      outr   <= '0;
      inport <= '0;
    end else begin
      if (io.reg_wr) r[io.reg_idx] <= bus;
      if (io.y_in)   y    <= bus;
      if (io.hi_in)  hi   <= bus;
      if (io.lo_in)  lo   <= bus;
      if (io.pc_in)  pc   <= bus;
      if (io.ir_in)  ir   <= bus;
      if (io.mar_in) mar  <= bus;
      if (io.out_in) outr <= bus;
      if (io.mdr_in) begin
        case (io.mdr_sel)
          2'd0:    mdr <= bus;
          2'd1:    mdr <= io.mem_rdata;
          2'd2:    mdr <= io.imm;
          default: mdr <= '0;
        endcase
      end
      inport <= io.inport_data;
    end
  end

  assign io.bus          = bus;
  assign io.mem_addr     = mar;
  assign io.mem_wdata    = mdr;
  assign io.outport_data = outr;
  assign io.ir_out       = ir;
  assign io.pc_out       = pc;
  assign io.busy         = busy;
  assign io.done         = done;
  assign io.dbz          = dbz;
endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: behavioural model checked every cycle on the 32-bit build,
// hand-computed literal expectations, and a 16-bit build MUL latency check.
module tb_param_datapath;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, reset16;
  always #5 clk = ~clk;

  param_datapath_if #(.WIDTH(32), .NREGS(16)) io ();
  param_datapath_if #(.WIDTH(16), .NREGS(16)) io16 ();

  param_datapath #(.WIDTH(32), .NREGS(16)) dut (.clk(clk), .reset(reset), .io(io));
  param_datapath #(.WIDTH(16), .NREGS(16)) dut16 (.clk(clk), .reset(reset16), .io(io16));

  int checks = 0;
  int passes = 0;
  bit chk_on = 1'b0;

  logic [W-1:0] m_r [16];
  logic [W-1:0] m_y, m_zhi, m_zlo, m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_out, m_inport;
  logic [W-1:0] m_a, m_b;
  logic         m_dbz, m_div;
  int           m_t;   // cycles since an accepted MUL/DIV start, 0 when none pending

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] model_bus();
    int s = int'(io.src_sel);
    if (s < 16) return (s == 0 && io.ba_out) ? '0 : m_r[s];
    case (s)
      16: return m_hi;
      17: return m_lo;
      18: return m_zhi;
      19: return m_zlo;
      20: return m_pc;
      21: return m_mdr;
      22: return m_inport;
      23: return io.imm;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, b);
    int unsigned s = b[4:0];
    logic [2*W-1:0] d = {a, a};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a >> s;
      4'd5:  return W'($signed(a) >>> s);
      4'd6:  return a << s;
      4'd7:  return W'(d >> s);
      4'd8:  begin d = d << s; return d[2*W-1:W]; end
      4'd9:  return -b;
      4'd10: return ~b;
      default: return b;
    endcase
  endfunction

  // {dbz, hi, lo}
  function automatic logic [2*W:0] mc_ref(input logic dv, input logic [W-1:0] a, b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p;
    if (!dv) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, a};
    return {1'b0, 32'(sa % sb), 32'(sa / sb)};
  endfunction

  task automatic cycle();
    logic [W-1:0] b;
    logic [W-1:0] nr [16];
    logic [W-1:0] ny, nzhi, nzlo, nhi, nlo, npc, nir, nmar, nmdr, nout, nin, na, nb;
    logic [2*W:0] mc;
    logic ndbz, ndiv;
    int nt;
    b = model_bus();
    nr = m_r; ny = m_y; nzhi = m_zhi; nzlo = m_zlo; nhi = m_hi; nlo = m_lo; npc = m_pc;
    nir = m_ir; nmar = m_mar; nmdr = m_mdr; nout = m_out; nin = m_inport; na = m_a; nb = m_b;
    ndbz = m_dbz; ndiv = m_div; nt = m_t;
    if (reset) begin
      for (int i = 0; i < 16; i++) nr[i] = '0;
      ny = '0; nzhi = '0; nzlo = '0; nhi = '0; nlo = '0; npc = '0; nir = '0; nmar = '0;
      nmdr = '0; nout = '0; nin = '0; ndbz = 1'b0; nt = 0;
    end else begin
      if (io.reg_wr) nr[io.reg_idx] = b;
      if (io.y_in)   ny = b;
      if (io.hi_in)  nhi = b;
      if (io.lo_in)  nlo = b;
      if (io.pc_in)  npc = b;
      if (io.ir_in)  nir = b;
      if (io.mar_in) nmar = b;
      if (io.out_in) nout = b;
      if (io.mdr_in) nmdr = (io.mdr_sel == 2'd0) ? b : (io.mdr_sel == 2'd1) ? io.mem_rdata :
                            (io.mdr_sel == 2'd2) ? io.imm : '0;
      nin = io.inport_data;
      if (m_t == W + 1) begin
        mc = mc_ref(m_div, m_a, m_b);
        ndbz = mc[2*W]; nzhi = mc[2*W-1:W]; nzlo = mc[W-1:0]; nt = 0;
      end else if (m_t > 0) begin
        nt = m_t + 1;
      end else if (io.alu_start && (io.alu_op == 4'd11 || io.alu_op == 4'd12)) begin
        nt = 1; na = m_y; nb = b; ndiv = (io.alu_op == 4'd12); ndbz = 1'b0;
      end else if (io.z_in && io.inc_pc) begin
        nzlo = b + 1; nzhi = '0;
      end else if (io.z_in && io.alu_op != 4'd11 && io.alu_op != 4'd12) begin
        nzlo = alu_ref(io.alu_op, m_y, b); nzhi = '0;
      end
    end
    @(posedge clk);
    #1;
    m_r = nr; m_y = ny; m_zhi = nzhi; m_zlo = nzlo; m_hi = nhi; m_lo = nlo; m_pc = npc;
    m_ir = nir; m_mar = nmar; m_mdr = nmdr; m_out = nout; m_inport = nin; m_a = na; m_b = nb;
    m_dbz = ndbz; m_div = ndiv; m_t = nt;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("bus", io.bus, model_bus());
        chk("mem_addr", io.mem_addr, m_mar);
        chk("mem_wdata", io.mem_wdata, m_mdr);
        chk("outport", io.outport_data, m_out);
        chk("ir_out", io.ir_out, m_ir);
        chk("pc_out", io.pc_out, m_pc);
        chk("busy", io.busy, (m_t >= 1 && m_t <= W));
        chk("done", io.done, (m_t == W + 1));
        chk("dbz", io.dbz, m_dbz);
      end
    end
  end

  task automatic idle_inputs();
    io.src_sel = 5'd0; io.ba_out = 1'b0; io.reg_wr = 1'b0; io.reg_idx = '0;
    io.y_in = 1'b0; io.z_in = 1'b0; io.hi_in = 1'b0; io.lo_in = 1'b0; io.pc_in = 1'b0;
    io.ir_in = 1'b0; io.mar_in = 1'b0; io.mdr_in = 1'b0; io.out_in = 1'b0;
    io.mdr_sel = 2'd0; io.inc_pc = 1'b0; io.alu_op = 4'd0; io.alu_start = 1'b0;
  endtask

  task automatic expect_bus(input string name, input logic [4:0] sel, input logic [W-1:0] exp);
    io.src_sel = sel;
    #1;
    chk(name, io.bus, exp);
  endtask

  task automatic set_r(input logic [3:0] idx, input logic [W-1:0] v);
    idle_inputs(); io.src_sel = 5'd23; io.imm = v; io.reg_wr = 1'b1; io.reg_idx = idx;
    cycle(); idle_inputs();
  endtask

  task automatic set_y(input logic [W-1:0] v);
    idle_inputs(); io.src_sel = 5'd23; io.imm = v; io.y_in = 1'b1;
    cycle(); idle_inputs();
  endtask

  // Start MUL/DIV, then keep z_in/alu_start/pc_in asserted while it runs (incl. the DONE cycle).
  task automatic run_mc(input logic [3:0] op, input logic [W-1:0] yv, bv,
                        output int busy_cnt, output int done_at);
    busy_cnt = 0; done_at = 0;
    set_y(yv);
    io.src_sel = 5'd23; io.imm = bv; io.alu_op = op; io.alu_start = 1'b1;
    cycle();
    idle_inputs();
    io.src_sel = 5'd23; io.imm = 32'h55; io.z_in = 1'b1; io.alu_start = 1'b1; io.pc_in = 1'b1;
    for (int k = 1; k <= W + 8; k++) begin
      if (io.busy === 1'b1) busy_cnt++;
      if (io.done === 1'b1 && done_at == 0) done_at = k;
      cycle();
      if (done_at != 0) break;
    end
    idle_inputs();
  endtask

  initial begin
    int bc, da, dc;
    logic [W-1:0] bvals [2];
    logic [W-1:0] mdr_exp [4];
    bvals = '{32'h4, 32'h1234_5678};
    mdr_exp = '{32'h1000, 32'h2001, 32'h1002, 32'h0};

    reset16 = 1'b1;
    io16.src_sel = 5'd0; io16.ba_out = 1'b0; io16.reg_wr = 1'b0; io16.reg_idx = '0;
    io16.y_in = 1'b0; io16.z_in = 1'b0; io16.hi_in = 1'b0; io16.lo_in = 1'b0;
    io16.pc_in = 1'b0; io16.ir_in = 1'b0; io16.mar_in = 1'b0; io16.mdr_in = 1'b0;
    io16.out_in = 1'b0; io16.mdr_sel = 2'd0; io16.inc_pc = 1'b0; io16.alu_op = 4'd0;
    io16.alu_start = 1'b0; io16.imm = '0; io16.mem_rdata = '0; io16.inport_data = '0;

    idle_inputs();
    io.imm = '0; io.mem_rdata = '0; io.inport_data = 32'hA5A5_0001;
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    chk_on = 1'b1;
    chk("reset_busy", io.busy, 1'b0);
    expect_bus("reset_zlo", 5'd19, 32'h0);

    set_r(4'd1, 32'd5);
    set_r(4'd2, 32'd7);
    io.src_sel = 5'd1; io.y_in = 1'b1; cycle(); idle_inputs();
    io.src_sel = 5'd2; io.alu_op = 4'd0; io.z_in = 1'b1; cycle(); idle_inputs();
    expect_bus("add_zlo", 5'd19, 32'd12);
    expect_bus("add_zhi", 5'd18, 32'd0);

    set_r(4'd0, 32'hFFFF);
    io.ba_out = 1'b1; expect_bus("ba_out_1", 5'd0, 32'h0); cycle();
    io.ba_out = 1'b0; expect_bus("ba_out_0", 5'd0, 32'hFFFF); cycle();
    io.src_sel = 5'd22; cycle();

    set_y(32'h8000_0F0F);
    for (int bi = 0; bi < 2; bi++) begin
      for (int op = 0; op <= 13; op++) begin
        if (op == 11 || op == 12) continue;
        io.src_sel = 5'd23; io.imm = bvals[bi]; io.alu_op = 4'(op); io.z_in = 1'b1;
        cycle(); idle_inputs();
        if (bi == 0 && op == 5) expect_bus("shra_lit", 5'd19, 32'hF800_00F0);
        if (bi == 0 && op == 8) expect_bus("rol_lit", 5'd19, 32'h0000_F0F8);
        io.src_sel = 5'd19; cycle();
      end
    end

    for (int s = 0; s < 4; s++) begin
      io.src_sel = 5'd23; io.imm = 32'h1000 + s; io.mem_rdata = 32'h2000 + s;
      io.mdr_in = 1'b1; io.mdr_sel = 2'(s);
      cycle(); idle_inputs();
      chk("mdr_sel", io.mem_wdata, mdr_exp[s]);
    end
    io.src_sel = 5'd23; io.imm = 32'hCAFE_0000; io.inport_data = 32'h0BAD_F00D;
    io.mar_in = 1'b1; io.out_in = 1'b1; io.ir_in = 1'b1; io.hi_in = 1'b1; io.lo_in = 1'b1;
    cycle(); idle_inputs();
    io.src_sel = 5'd16; cycle();
    io.src_sel = 5'd17; cycle();
    io.src_sel = 5'd22; cycle();

    run_mc(4'd11, 32'hFFFF_FFFA, 32'd7, bc, da);
    chk("mul_busy_cycles", bc, 32);
    chk("mul_done_cycle", da, 33);
    expect_bus("mul_zhi", 5'd18, 32'hFFFF_FFFF);
    expect_bus("mul_zlo", 5'd19, 32'hFFFF_FFD6);

    run_mc(4'd12, 32'hFFFF_FFF9, 32'd2, bc, da);
    expect_bus("div_zlo", 5'd19, 32'hFFFF_FFFD);
    expect_bus("div_zhi", 5'd18, 32'hFFFF_FFFF);
    chk("div_dbz", io.dbz, 1'b0);
    run_mc(4'd12, 32'hFFFF_FFF9, 32'd0, bc, da);
    expect_bus("dbz_zlo", 5'd19, 32'hFFFF_FFFF);
    expect_bus("dbz_zhi", 5'd18, 32'hFFFF_FFF9);
    cycle(); cycle();
    chk("dbz_flag", io.dbz, 1'b1);
    run_mc(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, bc, da);
    expect_bus("ovf_zlo", 5'd19, 32'h8000_0000);
    expect_bus("ovf_zhi", 5'd18, 32'h0);
    chk("ovf_dbz_cleared", io.dbz, 1'b0);

    set_y(32'hFFFF_FFFA);
    io.src_sel = 5'd23; io.imm = 32'd7; io.alu_op = 4'd11; io.alu_start = 1'b1;
    cycle(); idle_inputs();
    for (int k = 0; k < 9; k++) cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("abort_busy", io.busy, 1'b0);
    dc = 0;
    for (int k = 0; k < W + 8; k++) begin
      if (io.done === 1'b1) dc++;
      cycle();
    end
    chk("abort_no_done", dc, 0);
    expect_bus("abort_zlo", 5'd19, 32'h0);
    expect_bus("abort_zhi", 5'd18, 32'h0);

    io.src_sel = 5'd23; io.imm = 32'h10; io.pc_in = 1'b1; cycle(); idle_inputs();
    chk("pc_out_lit", io.pc_out, 32'h10);
    io.src_sel = 5'd20; io.inc_pc = 1'b1; io.z_in = 1'b1; io.alu_op = 4'd5;
    cycle(); idle_inputs();
    expect_bus("inc_pc_zlo", 5'd19, 32'h11);
    cycle();
    chk_on = 1'b0;

    // 16-bit build: same MUL, 16 busy cycles and done on the 17th
    @(posedge clk); #1; reset16 = 1'b0;
    io16.src_sel = 5'd23; io16.imm = 16'hFFFA; io16.y_in = 1'b1;
    @(posedge clk); #1;
    io16.y_in = 1'b0; io16.imm = 16'd7; io16.alu_op = 4'd11; io16.alu_start = 1'b1;
    @(posedge clk); #1;
    io16.alu_start = 1'b0;
    bc = 0; da = 0;
    for (int k = 1; k <= 30; k++) begin
      if (io16.busy === 1'b1) bc++;
      if (io16.done === 1'b1 && da == 0) da = k;
      @(posedge clk); #1;
      if (da != 0) break;
    end
    chk("w16_busy_cycles", bc, 16);
    chk("w16_done_cycle", da, 17);
    io16.src_sel = 5'd19; #1;
    chk("w16_zlo", io16.bus, 16'hFFD6);
    io16.src_sel = 5'd18; #1;
    chk("w16_zhi", io16.bus, 16'hFFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
